// File: rtl/store_align_rmw.sv
// Sub-word load/store unit: aligns, merges (read-modify-write) and extends data between the CPU
// and a word-wide memory. Define MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning.
module store_align_rmw #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              misalign
);

  localparam int unsigned WordBytes = DATA_W / 8;
  localparam int unsigned OffsW     = $clog2(WordBytes);
  localparam int unsigned LatW      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  function automatic int unsigned size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return WordBytes;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [LatW-1:0]     lat_q, lat_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                store_q;
  logic                uns_q;
  logic [DATA_W-1:0]   rd_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                accept;
  logic                capture;
  logic                trap;
  int unsigned         in_bytes;
  int unsigned         q_bytes;
  int unsigned         q_off;
  logic [DATA_W-1:0]   field_mask;
  logic [DATA_W-1:0]   lane_mask;
  logic [DATA_W-1:0]   rd_sh;
  logic [DATA_W-1:0]   load_val;
  logic                sign_bit;

  assign in_bytes = size_bytes(size);

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  assign trap     = (32'(addr[OffsW-1:0]) & (in_bytes - 1)) != 0;
  assign misalign = mis_q & done;
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept = 1'b1;
          lat_d  = '0;
          if (trap)                                 state_d = StDone;
          else if (is_store && in_bytes == WordBytes) state_d = StWr;
          else                                      state_d = StRd;
        end
      end
      StRd: begin
        if (lat_q == LatW'(MEM_LAT - 1)) begin
          capture = 1'b1;
          lat_d   = '0;
          state_d = store_q ? StWr : StDone;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StWr:   state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Lane offset is aligned down to the access size so lanes never run past the word end.
  always_comb begin
    q_bytes = size_bytes(size_q);
    q_off   = 32'(addr_q[OffsW-1:0]) & ~(q_bytes - 1);
    if (q_bytes >= WordBytes) field_mask = '1;
    else                      field_mask = (DATA_W'(1) << (8 * q_bytes)) - DATA_W'(1);
    lane_mask = field_mask << (8 * q_off);
    mem_wdata = ((wdata_q << (8 * q_off)) & lane_mask) | (rd_q & ~lane_mask);
    rd_sh     = mem_rdata >> (8 * q_off);
    if (q_bytes == 1)      sign_bit = rd_sh[7];
    else if (q_bytes == 2) sign_bit = rd_sh[15];
    else if (q_bytes == 4) sign_bit = rd_sh[31];
    else                   sign_bit = rd_sh[DATA_W-1];
    load_val = (rd_sh & field_mask) | ({DATA_W{~uns_q & sign_bit}} & ~field_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      lat_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      rd_q    <= '0;
      rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (accept) begin
        addr_q  <= addr;
        size_q  <= size;
        wdata_q <= wdata;
        store_q <= is_store;
        uns_q   <= unsigned_ld;
`ifdef MISALIGN_TRAP_EN
        mis_q   <= trap;
`endif
      end
      if (capture) begin
        rd_q <= mem_rdata;
        if (!store_q) rdata_q <= load_val;
      end
    end
  end

  assign mem_addr = {addr_q[ADDR_W-1:OffsW], {OffsW{1'b0}}};
  assign rdata    = rdata_q;
  assign busy     = state_q != StIdle;
  // Gated so a reset cycle never shows a write strobe or a completion.
  assign mem_wr   = (state_q == StWr) & ~reset;
  assign done     = (state_q == StDone) & ~reset;

endmodule
